// File: rtl/ula_mul_div_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide unit.
package ula_md_pkg;

  localparam int MD_XLEN  = 64;
  localparam int MD_STEPS = 64;
  localparam int MD_CNT_W = $clog2(MD_STEPS);

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } md_state_t;

  function automatic logic [MD_XLEN-1:0] md_abs(input logic [MD_XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/ula_mul_div.sv
// Radix-2 multiply/divide unit: magnitudes are processed for 64 cycles on a
// shared hi/lo register pair, then sign-corrected in FINISH.
module ula_mul_div
  import ula_md_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            START,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  md_state_t             r_state;
  md_state_t             w_state_next;
  md_op_t                r_op;
  logic                  r_neg;
  logic                  r_done;
  logic [MD_CNT_W-1:0]   r_cnt;
  logic [XLEN-1:0]       r_hi;
  logic [XLEN-1:0]       r_lo;
  logic [XLEN-1:0]       r_opb;
  logic [XLEN-1:0]       r_result;

  md_op_t                w_op;
  logic                  w_sa;
  logic                  w_sb;
  logic                  w_rem_op;
  logic                  w_div_zero;
  logic                  w_ovf;
  logic                  w_special;
  logic [XLEN-1:0]       w_special_val;
  logic [XLEN-1:0]       w_abs_a;
  logic [XLEN-1:0]       w_abs_b;
  logic [XLEN:0]         w_mul_sum;
  logic [XLEN:0]         w_div_trial;
  logic [XLEN-1:0]       w_step_hi;
  logic [XLEN-1:0]       w_step_lo;
  logic [2*XLEN-1:0]     w_prod_neg;
  logic [XLEN-1:0]       w_fin;

  assign w_op     = md_op_t'(OP);
  assign w_rem_op = OP[2] & OP[1];

  // Which operands are treated as signed for the requested operation.
  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    unique case (w_op)
      MD_MULH, MD_DIV, MD_REM: begin
        w_sa = A[XLEN-1];
        w_sb = B[XLEN-1];
      end
      MD_MULHSU: w_sa = A[XLEN-1];
      default: ;
    endcase
  end

  assign w_abs_a    = md_abs(A, w_sa);
  assign w_abs_b    = md_abs(B, w_sb);
  assign w_div_zero = OP[2] && (B == '0);
  assign w_ovf      = (w_op == MD_DIV || w_op == MD_REM) &&
                      (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
  assign w_special  = w_div_zero | w_ovf;

  always_comb begin
    w_special_val = '0;
    if (w_div_zero) begin
      w_special_val = w_rem_op ? A : '1;
    end else begin
      w_special_val = w_rem_op ? '0 : A;
    end
  end

  // Multiply: hi accumulates the multiplicand, {hi,lo} shifts right.
  // Divide: {rem,quo} shifts left, quotient bits enter at lo[0].
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
  assign w_div_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_opb};

  always_comb begin
    w_step_hi = '0;
    w_step_lo = '0;
    if (r_op[2]) begin
      if (!w_div_trial[XLEN]) begin
        w_step_hi = w_div_trial[XLEN-1:0];
        w_step_lo = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_step_hi = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
        w_step_lo = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_step_hi = w_mul_sum[XLEN:1];
      w_step_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  assign w_prod_neg = -{r_hi, r_lo};

  always_comb begin
    w_fin = '0;
    unique case (r_op)
      MD_MUL:                       w_fin = r_neg ? w_prod_neg[XLEN-1:0] : r_lo;
      MD_MULH, MD_MULHSU, MD_MULHU: w_fin = r_neg ? w_prod_neg[2*XLEN-1:XLEN] : r_hi;
      MD_DIV, MD_DIVU:              w_fin = r_neg ? -r_lo : r_lo;
      MD_REM, MD_REMU:              w_fin = r_neg ? -r_hi : r_hi;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (START) w_state_next = w_special ? FINISH : CALC;
      CALC:    if (r_cnt == MD_CNT_W'(MD_STEPS - 1)) w_state_next = FINISH;
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= MD_MUL;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (START) begin
            r_op  <= w_op;
            r_cnt <= '0;
            if (w_special) begin
              // Special results go straight to the half FINISH will select.
              r_neg <= 1'b0;
              r_opb <= '0;
              r_hi  <= w_rem_op ? w_special_val : '0;
              r_lo  <= w_rem_op ? '0 : w_special_val;
            end else if (OP[2]) begin
              r_neg <= w_rem_op ? w_sa : (w_sa ^ w_sb);
              r_hi  <= '0;
              r_lo  <= w_abs_a;
              r_opb <= w_abs_b;
            end else begin
              r_neg <= w_sa ^ w_sb;
              r_hi  <= '0;
              r_lo  <= w_abs_b;
              r_opb <= w_abs_a;
            end
          end
        end
        CALC: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt + MD_CNT_W'(1);
        end
        FINISH: begin
          r_result <= w_fin;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY   = (r_state != IDLE);
  assign DONE   = r_done;
  assign RESULT = r_result;

endmodule

// File: tb/tb_ula_mul_div.sv
// Self-checking bench for ula_mul_div: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_ula_mul_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  OP = 3'd0;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic        BUSY;
  logic        DONE;
  logic [63:0] RESULT;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  ula_mul_div #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .START(START), .OP(OP), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
      3'd4: begin
        if (b == 0) return ONES;
        if (a == MIN64 && b == ONES) return a;
        return sa / sb;
      end
      3'd5: return (b == 0) ? ONES : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN64 && b == ONES) return 64'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op[2] && b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == MIN64 && b == ONES) return 2;
    return 66;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one START edge; returns at the negedge after that edge.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    START = 1'b1; OP = op; A = a; B = b;
    @(negedge clk);
    START = 1'b0;
    OP = 3'($urandom);
    A = {$urandom, $urandom};
    B = {$urandom, $urandom};
  endtask

  task automatic wait_done(inout int cyc, inout int busy);
    while (!DONE && cyc < 300) begin
      if (BUSY) busy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int cyc;
    int busy;
    int lat;
    cyc = 1;
    busy = 0;
    lat = ref_lat(op, a, b);
    issue(op, a, b);
    wait_done(cyc, busy);
    $display("%s op=%0d a=%h b=%h result=%h cycles=%0d busy=%0d", tag, op, a, b, RESULT, cyc, busy);
    chk({tag, "_result"}, RESULT, ref_md(op, a, b));
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    chk({tag, "_busy_cycles"}, 64'(busy), 64'(lat - 1));
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 64'($urandom_range(0, 20));
      1: return ONES - 64'($urandom_range(0, 20));
      2: return MIN64;
      3: return 64'd0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int cyc;
    int busy;
    int dones;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [2:0]  rop;

    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(BUSY), 64'd0);
    chk("reset_done", 64'(DONE), 64'd0);
    chk("reset_result", RESULT, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_7_m3", 3'd0, 64'd7, ONES - 64'd2);
    @(negedge clk);
    chk("done_one_cycle", 64'(DONE), 64'd0);
    chk("result_held", RESULT, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op("mulhu_ones", 3'd3, ONES, ONES);
    run_op("mulh_ones", 3'd1, ONES, ONES);
    run_op("div_m7_2", 3'd4, ONES - 64'd6, 64'd2);
    run_op("rem_m7_2", 3'd6, ONES - 64'd6, 64'd2);
    run_op("divu_100_7", 3'd5, 64'd100, 64'd7);
    run_op("remu_100_7", 3'd7, 64'd100, 64'd7);
    run_op("divu_by0", 3'd5, 64'd10, 64'd0);
    run_op("remu_by0", 3'd7, 64'd10, 64'd0);
    run_op("div_ovf", 3'd4, MIN64, ONES);
    run_op("rem_ovf", 3'd6, MIN64, ONES);
    run_op("mulhsu_neg", 3'd2, ONES - 64'd4, 64'h1_0000_0003);

    // START while busy must be ignored.
    cyc = 1;
    busy = 0;
    issue(3'd0, 64'd123456789, 64'd987654321);
    repeat (19) begin
      if (BUSY) busy++;
      @(negedge clk);
      cyc++;
    end
    START = 1'b1; OP = 3'd1; A = ONES; B = 64'd5;
    if (BUSY) busy++;
    @(negedge clk);
    cyc++;
    START = 1'b0;
    wait_done(cyc, busy);
    $display("ignore_start result=%h cycles=%0d busy=%0d", RESULT, cyc, busy);
    chk("ignore_start_result", RESULT, 64'd121932631112635269);
    chk("ignore_start_latency", 64'(cyc), 64'd66);

    // Back-to-back: START in the DONE cycle is accepted.
    cyc = 1;
    busy = 0;
    issue(3'd4, 64'd1000, ONES - 64'd9);
    wait_done(cyc, busy);
    chk("b2b_first_result", RESULT, ONES - 64'd99);
    cyc = 1;
    busy = 0;
    issue(3'd5, 64'd1000, 64'd33);
    wait_done(cyc, busy);
    $display("b2b_second result=%h cycles=%0d", RESULT, cyc);
    chk("b2b_second_result", RESULT, 64'd30);
    chk("b2b_second_latency", 64'(cyc), 64'd66);

    // Reset mid-divide aborts with no late DONE.
    cyc = 1;
    busy = 0;
    issue(3'd4, 64'd12345, 64'd7);
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(BUSY), 64'd0);
    chk("abort_result", RESULT, 64'd0);
    chk("abort_done", 64'(DONE), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (80) begin
      @(negedge clk);
      if (DONE) dones++;
    end
    $display("after_abort dones=%0d", dones);
    chk("abort_no_done", 64'(dones), 64'd0);
    run_op("mul_3_5", 3'd0, 64'd3, 64'd5);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op("rand", rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
